// File: rtl/iob_nco_sweep_pkg.sv
// Shared state encoding and clamped next-period arithmetic for the NCO sweep scheduler.
package iob_nco_sweep_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_INIT  = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_DWELL = 3'd3;
  localparam state_t ST_HOLD  = 3'd4;

  localparam int CALC_W = 64;

  // Step toward tgt, landing on tgt exactly when the step would reach or pass it.
  // Comparing against the remaining distance avoids any wrap in the period width.
  function automatic logic [CALC_W-1:0] clamp_next(input logic [CALC_W-1:0] cur,
                                                   input logic [CALC_W-1:0] step,
                                                   input logic [CALC_W-1:0] tgt,
                                                   input logic              up);
    logic [CALC_W-1:0] res;
    if (up) res = ((cur >= tgt) || (step >= tgt - cur)) ? tgt : cur + step;
    else    res = ((cur <= tgt) || (step >= cur - tgt)) ? tgt : cur - step;
    return res;
  endfunction

endpackage

// File: rtl/iob_nco_sweep_step.sv
// Combinational next-period calculator: clamped step toward the current target plus last-step flag.
module iob_nco_sweep_step
  import iob_nco_sweep_pkg::*;
#(
  parameter int PERIOD_W = 40
) (
  input  logic [PERIOD_W-1:0] cur_i,
  input  logic [PERIOD_W-1:0] step_i,
  input  logic [PERIOD_W-1:0] tgt_i,
  input  logic                up_i,
  output logic [PERIOD_W-1:0] next_o,
  output logic                last_o
);

  assign next_o = PERIOD_W'(clamp_next(CALC_W'(cur_i), CALC_W'(step_i), CALC_W'(tgt_i), up_i));
  // A zero step can never reach the target, so the current period is the last one.
  assign last_o = (cur_i == tgt_i) || (step_i == '0);

endmodule

// File: rtl/iob_nco_sweep.sv
// Frequency-sweep scheduler feeding period updates into an iob_nco.
// Optional macro IOB_NCO_SWEEP_BIDIR_EN: loop mode ping-pongs start<->stop instead of sawtooth.
module iob_nco_sweep
  import iob_nco_sweep_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 8,
  parameter int DWELL_W = 24
) (
  input  logic                       clk_i,
  input  logic                       cke_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [DATA_W+FRAC_W-1:0]   cfg_start_i,
  input  logic [DATA_W+FRAC_W-1:0]   cfg_stop_i,
  input  logic [DATA_W+FRAC_W-1:0]   cfg_step_i,
  input  logic [DWELL_W-1:0]         cfg_dwell_i,
  input  logic                       cfg_loop_i,
  output logic [DATA_W+FRAC_W-1:0]   period_o,
  output logic                       period_valid_o,
  input  logic                       period_ready_i,
  output logic                       nco_enable_o,
  output logic                       nco_soft_reset_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [DATA_W-1:0]          step_idx_o
);

  localparam int PERIOD_W = DATA_W + FRAC_W;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] start_q, stop_q, step_q;
  logic [PERIOD_W-1:0] cur_q, cur_d, tgt_q, tgt_d, next_w;
  logic [DWELL_W-1:0]  dwell_q, cnt_q, cnt_d;
  logic [DATA_W-1:0]   idx_q, idx_d;
  logic                loop_q, up0_q, up_q, up_d, ret_q, ret_d;
  logic                en_q, en_d, done_q, done_d;
  logic                last_w, expire_w, latch_w;

  iob_nco_sweep_step #(.PERIOD_W(PERIOD_W)) u_step (
    .cur_i  (cur_q),
    .step_i (step_q),
    .tgt_i  (tgt_q),
    .up_i   (up_q),
    .next_o (next_w),
    .last_o (last_w)
  );

  assign expire_w = (state_q == ST_DWELL) && (cnt_q == '0);
  assign latch_w  = (state_q == ST_IDLE) && start_i && !abort_i;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i && !abort_i) state_d = ST_INIT;
      ST_INIT:  state_d = ST_WRITE;
      ST_WRITE: if (period_ready_i) state_d = ST_DWELL;
      ST_DWELL: if (expire_w) state_d = (last_w && !loop_q) ? ST_HOLD : ST_WRITE;
      ST_HOLD:  if (start_i) state_d = ST_INIT;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_comb begin
    cur_d  = cur_q;
    tgt_d  = tgt_q;
    up_d   = up_q;
    ret_d  = ret_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    done_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        cur_d = start_q;
        tgt_d = stop_q;
        up_d  = up0_q;
        ret_d = 1'b0;
        idx_d = '0;
      end
      ST_WRITE: if (period_ready_i) begin
        en_d  = 1'b1;
        cnt_d = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
      end
      ST_DWELL: begin
        if (!expire_w) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (!last_w) begin
          cur_d = next_w;
          idx_d = ret_q ? idx_q - DATA_W'(1) : idx_q + DATA_W'(1);
        end else if (!loop_q) begin
          done_d = 1'b1;
        end else begin
`ifdef IOB_NCO_SWEEP_BIDIR_EN
          // Reverse at the endpoint and step straight away from it so it is not rewritten.
          ret_d = !ret_q;
          up_d  = !up_q;
          tgt_d = ret_q ? stop_q : start_q;
          cur_d = PERIOD_W'(clamp_next(CALC_W'(cur_q), CALC_W'(step_q),
                                       CALC_W'(ret_q ? stop_q : start_q), !up_q));
          if ((step_q != '0) && (start_q != stop_q))
            idx_d = ret_q ? idx_q + DATA_W'(1) : idx_q - DATA_W'(1);
`else
          cur_d = start_q;
          idx_d = '0;
`endif
        end
      end
      default: ;
    endcase
    if (state_d == ST_IDLE) en_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        start_q <= '0;
        stop_q  <= '0;
        step_q  <= '0;
        dwell_q <= '0;
        loop_q  <= 1'b0;
        up0_q   <= 1'b0;
        cur_q   <= '0;
        tgt_q   <= '0;
        up_q    <= 1'b0;
        ret_q   <= 1'b0;
        idx_q   <= '0;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        if (latch_w) begin
          start_q <= cfg_start_i;
          stop_q  <= cfg_stop_i;
          step_q  <= cfg_step_i;
          dwell_q <= cfg_dwell_i;
          loop_q  <= cfg_loop_i;
          up0_q   <= (cfg_stop_i >= cfg_start_i);
        end
        cur_q  <= cur_d;
        tgt_q  <= tgt_d;
        up_q   <= up_d;
        ret_q  <= ret_d;
        idx_q  <= idx_d;
        cnt_q  <= cnt_d;
        en_q   <= en_d;
        done_q <= done_d;
      end
    end
  end

  always_comb begin
    period_valid_o   = (state_q == ST_WRITE);
    nco_soft_reset_o = (state_q == ST_INIT);
    busy_o           = (state_q == ST_INIT) || (state_q == ST_WRITE) || (state_q == ST_DWELL);
  end

  assign period_o     = cur_q;
  assign nco_enable_o = en_q;
  assign done_o       = done_q;
  assign step_idx_o   = idx_q;

endmodule

// File: tb/tb_iob_nco_sweep.sv
// Self-checking bench for iob_nco_sweep: a list-based sweep model checked on every handshake plus directed literals.
module tb_iob_nco_sweep;

  localparam int DW = 32;
  localparam int PW = 40;
  localparam int WW = 24;

  logic          clk = 1'b0;
  logic          cke = 1'b1;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
  logic [WW-1:0] cfg_dwell = '0;
  logic          cfg_loop = 1'b0;
  logic          ready = 1'b0;
  logic [PW-1:0] period;
  logic          valid, nco_en, soft_rst, busy, done;
  logic [DW-1:0] step_idx;

  iob_nco_sweep dut (
    .clk_i            (clk),
    .cke_i            (cke),
    .rst_n_i          (rst_n),
    .start_i          (start),
    .abort_i          (abort),
    .cfg_start_i      (cfg_start),
    .cfg_stop_i       (cfg_stop),
    .cfg_step_i       (cfg_step),
    .cfg_dwell_i      (cfg_dwell),
    .cfg_loop_i       (cfg_loop),
    .period_o         (period),
    .period_valid_o   (valid),
    .period_ready_i   (ready),
    .nco_enable_o     (nco_en),
    .nco_soft_reset_o (soft_rst),
    .busy_o           (busy),
    .done_o           (done),
    .step_idx_o       (step_idx)
  );

  always #5 clk = ~clk;

  int            ntest = 0;
  int            nfail = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            sr_cnt = 0;
  int            exp_base = 0;
  logic [PW-1:0] exp_p[$];
  int            exp_i[$];
  logic [PW-1:0] act_p[$];
  int            hs_cyc[$];
  logic          pv_q = 1'b0, pr_q = 1'b0, pab_q = 1'b0, prst_q = 1'b0, pd_q = 1'b0, ps_q = 1'b0;
  logic [PW-1:0] pp_q = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle observer: every accepted period is checked against the model list.
  task automatic sample();
    logic hs;
    int   k;
    hs = valid && ready && cke && rst_n && !abort;
    if (hs === 1'b1) begin
      k = act_p.size() - exp_base;
      if (k < exp_p.size()) begin
        check("write_period", 64'(period), 64'(exp_p[k]));
        check("write_idx", 64'(step_idx), 64'(exp_i[k]));
      end else begin
        check("extra_write", 64'(k), 64'(exp_p.size()));
      end
      act_p.push_back(period);
      hs_cyc.push_back(cyc);
    end
    if (pv_q && !pr_q && !pab_q && prst_q) begin
      check("hold_valid", 64'(valid), 64'd1);
      check("hold_period", 64'(period), 64'(pp_q));
    end
    if (valid === 1'b1) check("busy_with_valid", 64'(busy), 64'd1);
    if (done === 1'b1 && !pd_q) done_cnt++;
    if (soft_rst === 1'b1 && !ps_q) sr_cnt++;
    pv_q   = (valid === 1'b1);
    pr_q   = ready;
    pab_q  = abort;
    prst_q = rst_n && cke;
    pd_q   = (done === 1'b1);
    ps_q   = (soft_rst === 1'b1);
    pp_q   = period;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Expected write sequence from the sweep rules: walk start->stop, clamping onto stop.
  task automatic build_exp(input logic [PW-1:0] s, input logic [PW-1:0] e,
                           input logic [PW-1:0] st, input logic lp);
    logic [PW-1:0] l[$];
    logic [PW-1:0] p;
    int            n, total, i, d;
    exp_p.delete();
    exp_i.delete();
    exp_base = act_p.size();
    p = s;
    l.push_back(p);
    while (p != e && st != 0) begin
      if (e >= s) p = (e - p <= st) ? e : p + st;
      else        p = (p - e <= st) ? e : p - st;
      l.push_back(p);
    end
    n = l.size();
    total = lp ? 3 * n : n;
    i = 0;
    d = 1;
    for (int k = 0; k < total; k++) begin
      exp_p.push_back(l[i]);
      exp_i.push_back(i);
`ifdef IOB_NCO_SWEEP_BIDIR_EN
      if (n > 1) begin
        if (i + d < 0 || i + d > n - 1) d = -d;
        i += d;
      end
`else
      i = (i + 1) % n;
`endif
    end
  endtask

  task automatic set_cfg(input logic [PW-1:0] s, input logic [PW-1:0] e, input logic [PW-1:0] st,
                         input int dw, input logic lp);
    cfg_start = s;
    cfg_stop  = e;
    cfg_step  = st;
    cfg_dwell = WW'(dw);
    cfg_loop  = lp;
    build_exp(s, e, st, lp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 64'(period), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_enable"}, 64'(nco_en), 64'd0);
    check({tag, "_softrst"}, 64'(soft_rst), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_idx"}, 64'(step_idx), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_hs(input int n, input string name);
    for (int i = 0; i < 200 && act_p.size() < n; i++) tick();
    check(name, 64'(act_p.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && valid !== 1'b1; i++) tick();
    check(name, 64'(valid), 64'd1);
  endtask

  function automatic int spacing(input int a, input int b);
    if (b >= hs_cyc.size()) return -1;
    return hs_cyc[b] - hs_cyc[a];
  endfunction

  int base, d0, s0;

  initial begin
    // Up sweep, one shot
    do_reset();
    set_cfg(40'h0A00, 40'h0D00, 40'h0100, 3, 1'b0);
    ready = 1'b1;
    base = act_p.size();
    d0 = done_cnt;
    pulse_start();
    cfg_stop = 40'h0F00;
    check("t1_softrst_lat1", 64'(soft_rst), 64'd1);
    check("t1_valid_lat1", 64'(valid), 64'd0);
    tick();
    check("t1_softrst_off", 64'(soft_rst), 64'd0);
    check("t1_valid_lat2", 64'(valid), 64'd1);
    check("t1_period0", 64'(period), 64'h0A00);
    wait_done(d0, "t1_done_once");
    check("t1_writes", 64'(act_p.size() - base), 64'd4);
    check("t1_write1", 64'(act_p.size() > base + 1 ? act_p[base + 1] : '0), 64'h0B00);
    check("t1_spacing", 64'(spacing(base, base + 1)), 64'd4);
    check("t1_span", 64'(spacing(base, base + 3)), 64'd12);
    check("t1_hold_busy", 64'(busy), 64'd0);
    check("t1_hold_enable", 64'(nco_en), 64'd1);
    check("t1_hold_period", 64'(period), 64'h0D00);
    check("t1_hold_idx", 64'(step_idx), 64'd3);
    check("t1_done_pulse", 64'(done), 64'd0);
    repeat (3) tick();
    check("t1_hold_stays", 64'(nco_en), 64'd1);
    check("t1_done_count", 64'(done_cnt - d0), 64'd1);

    // Clamped down sweep
    do_reset();
    set_cfg(40'h1000, 40'h0C80, 40'h0200, 2, 1'b0);
    base = act_p.size();
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, "t2_done");
    check("t2_writes", 64'(act_p.size() - base), 64'd3);
    check("t2_write1", 64'(act_p.size() > base + 1 ? act_p[base + 1] : '0), 64'h0E00);
    check("t2_period_end", 64'(period), 64'h0C80);
    check("t2_idx_end", 64'(step_idx), 64'd2);

    // Backpressure on the second write
    do_reset();
    set_cfg(40'h0A00, 40'h0D00, 40'h0100, 3, 1'b0);
    base = act_p.size();
    d0 = done_cnt;
    pulse_start();
    wait_hs(base + 1, "t3_first_hs");
    ready = 1'b0;
    wait_valid("t3_second_valid");
    check("t3_second_period", 64'(period), 64'h0B00);
    repeat (5) tick();
    ready = 1'b1;
    wait_done(d0, "t3_done");
    check("t3_bp_spacing", 64'(spacing(base, base + 1)), 64'd9);
    check("t3_dwell_after_hs", 64'(spacing(base + 1, base + 2)), 64'd4);
    check("t3_writes", 64'(act_p.size() - base), 64'd4);

    // Loop mode
    do_reset();
    set_cfg(40'h0A00, 40'h0D00, 40'h0100, 3, 1'b1);
    base = act_p.size();
    d0 = done_cnt;
    s0 = sr_cnt;
    pulse_start();
    wait_hs(base + 6, "t4_six_writes");
`ifdef IOB_NCO_SWEEP_BIDIR_EN
    check("t4_after_stop", 64'(act_p.size() > base + 4 ? act_p[base + 4] : '0), 64'h0C00);
`else
    check("t4_after_stop", 64'(act_p.size() > base + 4 ? act_p[base + 4] : '0), 64'h0A00);
`endif
    check("t4_softrst_once", 64'(sr_cnt - s0), 64'd1);
    check("t4_no_done", 64'(done_cnt - d0), 64'd0);
    check("t4_busy", 64'(busy), 64'd1);
    pulse_abort();
    check("t4_abort_busy", 64'(busy), 64'd0);
    check("t4_abort_enable", 64'(nco_en), 64'd0);

    // Abort mid-handshake, then restart
    do_reset();
    set_cfg(40'h0A00, 40'h0D00, 40'h0100, 3, 1'b0);
    base = act_p.size();
    d0 = done_cnt;
    pulse_start();
    wait_hs(base + 1, "t5_first_hs");
    ready = 1'b0;
    wait_valid("t5_second_valid");
    repeat (2) tick();
    check("t5_enable_before", 64'(nco_en), 64'd1);
    pulse_abort();
    check("t5_valid_dropped", 64'(valid), 64'd0);
    check("t5_enable_dropped", 64'(nco_en), 64'd0);
    check("t5_busy_dropped", 64'(busy), 64'd0);
    repeat (2) tick();
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    build_exp(40'h0A00, 40'h0D00, 40'h0100, 1'b0);
    pulse_start();
    check("t5_restart_softrst", 64'(soft_rst), 64'd1);
    check("t5_restart_valid1", 64'(valid), 64'd0);
    tick();
    check("t5_restart_valid2", 64'(valid), 64'd1);
    check("t5_restart_period", 64'(period), 64'h0A00);
    pulse_abort();

    // Start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort_busy", 64'(busy), 64'd0);
    check("t5_start_abort_softrst", 64'(soft_rst), 64'd0);

    // Reset mid-dwell
    do_reset();
    ready = 1'b1;
    set_cfg(40'h0A00, 40'h0D00, 40'h0100, 3, 1'b0);
    base = act_p.size();
    pulse_start();
    wait_hs(base + 2, "t6_two_writes");
    tick();
    check("t6_enable_mid", 64'(nco_en), 64'd1);
    rst_n = 1'b0;
    tick();
    check_zero("t6_rst");
    rst_n = 1'b1;

    // Clock-enable freeze mid-dwell
    build_exp(40'h0A00, 40'h0D00, 40'h0100, 1'b0);
    base = act_p.size();
    d0 = done_cnt;
    pulse_start();
    wait_hs(base + 2, "t6_cke_two_writes");
    cke = 1'b0;
    repeat (4) tick();
    check("t6_frozen_idx", 64'(step_idx), 64'd1);
    cke = 1'b1;
    wait_done(d0, "t6_cke_done");
    check("t6_cke_normal", 64'(spacing(base, base + 1)), 64'd4);
    check("t6_cke_stretch", 64'(spacing(base + 1, base + 2)), 64'd8);
    check("t6_cke_writes", 64'(act_p.size() - base), 64'd4);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
